// File: rtl/ecg_nn_pkg.sv
// Shared types and default sizes for the ECG neural-network datapath.
package ecg_nn_pkg;

    localparam int ACT_W    = 8;
    localparam int N_IN     = 15;
    localparam int NODE_LAT = 3;

    typedef logic signed [ACT_W-1:0] act_t;

    typedef enum logic {
        FILL,
        RUN
    } feeder_state_t;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register that tracks a valid pulse through the node pipeline.
module valid_delay_line #(
    parameter int DEPTH = ecg_nn_pkg::NODE_LAT
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/node_window_feeder.sv
// Sliding-window producer for the node activation bus (N_IN >= 2 assumed).
// Define FEEDER_ZERO_PAD_EN to issue windows from the first sample with zero-filled missing taps.
module node_window_feeder
    import ecg_nn_pkg::*;
#(
    parameter int N_IN     = ecg_nn_pkg::N_IN,
    parameter int ACT_W    = ecg_nn_pkg::ACT_W,
    parameter int STRIDE   = 1,
    parameter int NODE_LAT = ecg_nn_pkg::NODE_LAT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    input  logic [ACT_W-1:0]      s_data,
    output logic                  s_ready,
    input  logic                  frame_st,
    output logic [N_IN*ACT_W-1:0] win_data,
    output logic                  win_valid,
    output logic                  res_valid,
    output logic [15:0]           win_cnt
);

`ifdef FEEDER_ZERO_PAD_EN
    localparam bit ZERO_PAD = 1'b1;
`else
    localparam bit ZERO_PAD = 1'b0;
`endif

    localparam feeder_state_t START_STATE = ZERO_PAD ? RUN : FILL;
    localparam int FW = $clog2(N_IN + 1);
    localparam int SW = $clog2(STRIDE + 1);
    localparam logic [FW-1:0] FILL_LAST   = FW'(N_IN - 1);
    localparam logic [SW-1:0] STRIDE_LAST = SW'(STRIDE - 1);
    localparam bit FRAME_ISSUES = ZERO_PAD && (STRIDE == 1);

    feeder_state_t state;
    logic [FW-1:0] fill_cnt;
    logic [SW-1:0] stride_cnt;
    logic          accept;
    logic          issue;

    assign accept = s_valid & s_ready;

    // A frame-start sample opens a fresh stride group; only zero-pad mode can complete one with it alone.
    always_comb begin
        issue = 1'b0;
        if (accept) begin
            if (frame_st) begin
                issue = FRAME_ISSUES;
            end else if (state == FILL) begin
                issue = (fill_cnt == FILL_LAST);
            end else begin
                issue = (stride_cnt == STRIDE_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= START_STATE;
            fill_cnt   <= '0;
            stride_cnt <= '0;
            win_data   <= '0;
            win_valid  <= 1'b0;
            win_cnt    <= '0;
            s_ready    <= 1'b0;
        end else begin
            s_ready   <= 1'b1;
            win_valid <= issue;
            if (accept) begin
                if (frame_st) begin
                    win_data   <= {s_data, {((N_IN-1)*ACT_W){1'b0}}};
                    state      <= START_STATE;
                    fill_cnt   <= FW'(1);
                    stride_cnt <= (FRAME_ISSUES || !ZERO_PAD) ? '0 : SW'(1);
                    win_cnt    <= FRAME_ISSUES ? 16'd1 : 16'd0;
                end else begin
                    win_data <= {s_data, win_data[N_IN*ACT_W-1:ACT_W]};
                    if (issue) begin
                        win_cnt <= win_cnt + 16'd1;
                    end
                    case (state)
                        FILL: begin
                            if (issue) begin
                                state      <= RUN;
                                stride_cnt <= '0;
                            end else begin
                                fill_cnt <= fill_cnt + 1'b1;
                            end
                        end
                        RUN: begin
                            stride_cnt <= issue ? '0 : stride_cnt + 1'b1;
                        end
                        default: state <= START_STATE;
                    endcase
                end
            end
        end
    end

    // In-flight results survive frame_st; only reset clears the pipeline.
    valid_delay_line #(
        .DEPTH(NODE_LAT)
    ) u_res_delay (
        .clk  (clk),
        .reset(reset),
        .din  (win_valid),
        .dout (res_valid)
    );

endmodule

// File: tb/tb_node_window_feeder.sv
// Bench for node_window_feeder: STRIDE=1 and STRIDE=4 instances share one input stream.
// Expected outputs come from a sample-history model built on the window/stride rules.
module tb_node_window_feeder;
    import ecg_nn_pkg::*;

    localparam int NI = 15;
    localparam int AW = 8;
    localparam int NL = 3;

`ifdef FEEDER_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           s_valid = 1'b0;
    logic           frame_st = 1'b0;
    act_t           s_data = '0;

    logic           rdy_a, rdy_b;
    logic [NI*AW-1:0] wd_a, wd_b;
    logic           wv_a, wv_b, rv_a, rv_b;
    logic [15:0]    wc_a, wc_b;

    int errors = 0;
    int checks = 0;

    // Model state: accepted samples since reset/frame, and per-instance window bookkeeping.
    int            cnt = 0;
    act_t          hist[$];
    bit            ready_m = 1'b0;
    bit            wv_m[2];
    logic [15:0]   wc_m[2];
    logic [NL:0]   dly_m[2];

    node_window_feeder #(.N_IN(NI), .ACT_W(AW), .STRIDE(1), .NODE_LAT(NL)) dut_a (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(rdy_a),
        .frame_st(frame_st), .win_data(wd_a), .win_valid(wv_a), .res_valid(rv_a), .win_cnt(wc_a)
    );

    node_window_feeder #(.N_IN(NI), .ACT_W(AW), .STRIDE(4), .NODE_LAT(NL)) dut_b (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(rdy_b),
        .frame_st(frame_st), .win_data(wd_b), .win_valid(wv_b), .res_valid(rv_b), .win_cnt(wc_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    function automatic int stride_of(input int m);
        return (m == 0) ? 1 : 4;
    endfunction

    function automatic bit window_due(input int c, input int s);
        if (PAD) return (c % s) == 0;
        return (c >= NI) && (((c - NI) % s) == 0);
    endfunction

    // Newest N_IN samples, right-aligned to tap N_IN-1, zeros where history is short.
    function automatic logic [NI*AW-1:0] expected_window();
        logic [NI*AW-1:0] w;
        int off;
        w = '0;
        off = NI - hist.size();
        for (int k = 0; k < NI; k++) begin
            if (k >= off) w[k*AW +: AW] = hist[k-off];
        end
        return w;
    endfunction

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_instance(input int m, input logic rdy, input logic [NI*AW-1:0] wd,
                                  input logic wv, input logic rv, input logic [15:0] wc);
        string p;
        p = $sformatf("s%0d_", stride_of(m));
        check_output({p, "s_ready"},   128'(rdy), 128'(ready_m));
        check_output({p, "win_valid"}, 128'(wv),  128'(wv_m[m]));
        check_output({p, "res_valid"}, 128'(rv),  128'(dly_m[m][NL]));
        check_output({p, "win_cnt"},   128'(wc),  128'(wc_m[m]));
        check_output({p, "win_data"},  128'(wd),  128'(expected_window()));
    endtask

    // One clock: drive inputs, advance the model at the edge, then compare both instances.
    task automatic apply_stimulus(input bit r, input bit v, input act_t d, input bit f);
        bit acc;
        reset = r;
        s_valid = v;
        s_data = d;
        frame_st = f;
        @(posedge clk);
        acc = v && ready_m && !r;
        if (r) begin
            cnt = 0;
            hist.delete();
            ready_m = 1'b0;
            for (int m = 0; m < 2; m++) begin
                wv_m[m] = 1'b0;
                wc_m[m] = '0;
                dly_m[m] = '0;
            end
        end else begin
            if (acc) begin
                if (f) begin
                    cnt = 0;
                    hist.delete();
                    wc_m[0] = '0;
                    wc_m[1] = '0;
                end
                cnt++;
                hist.push_back(d);
                if (hist.size() > NI) void'(hist.pop_front());
            end
            for (int m = 0; m < 2; m++) begin
                wv_m[m] = acc && window_due(cnt, stride_of(m));
                if (wv_m[m]) wc_m[m] = wc_m[m] + 16'd1;
                dly_m[m] = {dly_m[m][NL-1:0], wv_m[m]};
            end
            ready_m = 1'b1;
        end
        #1;
        check_instance(0, rdy_a, wd_a, wv_a, rv_a, wc_a);
        check_instance(1, rdy_b, wd_b, wv_b, rv_b, wc_b);
    endtask

    initial begin
        bit armed;

        // Reset state.
        repeat (3) apply_stimulus(1'b1, 1'b0, '0, 1'b0);
        apply_stimulus(1'b0, 1'b0, '0, 1'b0);

        // Ramp 1..15, then drain to observe res_valid.
        for (int i = 1; i <= 15; i++) apply_stimulus(1'b0, 1'b1, act_t'(i), 1'b0);
        repeat (5) apply_stimulus(1'b0, 1'b0, '0, 1'b0);

        // Back-to-back 16, 17.
        apply_stimulus(1'b0, 1'b1, act_t'(16), 1'b0);
        apply_stimulus(1'b0, 1'b1, act_t'(17), 1'b0);
        repeat (5) apply_stimulus(1'b0, 1'b0, '0, 1'b0);

        // Random samples with gaps.
        for (int i = 0; i < 40; i++)
            apply_stimulus(1'b0, ($urandom_range(0, 9) < 7), act_t'($urandom), 1'b0);

        // Frame start on 0x80 while results are in flight, plus frame_st without a valid.
        apply_stimulus(1'b0, 1'b1, act_t'(8'h80), 1'b1);
        apply_stimulus(1'b0, 1'b0, act_t'($urandom), 1'b1);
        for (int i = 0; i < 30; i++)
            apply_stimulus(1'b0, ($urandom_range(0, 9) < 8), act_t'($urandom), ($urandom_range(0, 9) == 0) && 1'b0);
        repeat (5) apply_stimulus(1'b0, 1'b0, '0, 1'b0);

        // Reset one cycle after a window issues: no results may follow.
        armed = 1'b0;
        for (int i = 0; i < 40 && !armed; i++) begin
            apply_stimulus(1'b0, 1'b1, act_t'($urandom), 1'b0);
            armed = wv_m[0];
        end
        check_output("reset_arm_win_valid", 128'(wv_a), 128'(1));
        apply_stimulus(1'b1, 1'b0, '0, 1'b0);
        repeat (6) apply_stimulus(1'b0, 1'b0, '0, 1'b0);

        // Long random run with occasional frame starts, including frame_st with s_valid low.
        for (int i = 0; i < 400; i++)
            apply_stimulus(1'b0, ($urandom_range(0, 9) < 7), act_t'($urandom),
                           ($urandom_range(0, 24) == 0));
        repeat (5) apply_stimulus(1'b0, 1'b0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
